lpc_synth: RTL and testbench
============================

# lpc_synth

LPC decoder/synthesizer, the receive-side counterpart of the LPC encoder: takes per-frame reflection-free direct-form predictor coefficients, voicing flag, pitch period and gain, and regenerates 16-bit speech samples at the 8 kHz sample rate via excitation generation plus a 10th-order all-pole filter. Runs in the 50 MHz system clock domain with a one-cycle sample strobe in place of a separate data clock. Same 16-bit register port style as the encoder for frame-length configuration and status.

## Interface
- ORDER, 10, predictor order (coefficient inputs a1..a10 fixed at 10; ORDER kept for MAC loop bound)
- FRAC, 12, fractional bits of coefficients (Q3.12 signed)
- FRAME_DEF, 240, reset value of frame length in samples
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-low reset
- samp_en  in  1  one-cycle strobe per output sample (8 kHz)
- load  in  1  one-cycle pulse: capture a1..a10, voiced, pitch, gain into shadow registers
- a1..a10  in  16 each  signed Q3.12 predictor coefficients
- voiced  in  1  1 = impulse-train excitation, 0 = noise
- pitch  in  16  pitch period in samples (0 treated as 1)
- gain  in  16  signed excitation amplitude
- y  out  16  signed synthesized sample
- y_valid  out  1  one-cycle pulse, y updated
- address  in  16  register address
- read, write  in  1  register strobes
- writedata  in  16  register write data
- readdata  out  16  register read data

## Operation
- Registers: addr 0 frame_len (R/W, reset FRAME_DEF, write of 0 stored as 1); addr 1 status (bit0 overrun sticky, write any value clears); other addresses read 0, writes ignored.
- Shadow set (coefs, voiced, pitch, gain) written on load; copied to active set when a sample starts with sample counter = 0. Active set resets to all zero.
- Sample counter counts 0..frame_len-1 per accepted samp_en, wraps to 0. Pitch counter counts 0..pitch-1, reset to 0 on each active-set copy.
- Excitation e: voiced → e = gain when pitch counter = 0, else 0. Unvoiced → 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, advances once per sample), e = (lfsr_signed * gain) >>> 15.
- Filter: acc = (e <<< FRAC) − Σ_{k=1..ORDER} a_k·y[n−k]; y = sat16(acc >>> FRAC) (arithmetic shift, saturate to ±32767/−32768). acc 40-bit signed. History is the saturated outputs, shifted after each sample.
- FSM: IDLE → (samp_en) EXC → MAC (k=1..ORDER, one multiply/cycle) → OUT → IDLE. Single shared 16×16 multiplier.
- samp_en while not IDLE: ignored, overrun set; no counter or LFSR advance.

## Timing
- samp_en sampled in cycle 0; y and y_valid asserted in cycle ORDER+3 (13); accepts next samp_en in cycle ORDER+3 onward.
- load coincident with an active-set copy: the copy uses the previous shadow contents; new values take effect next frame.
- Register write takes effect next cycle; readdata registered, valid the cycle after read, holds until next read.
- Reset values: y = 0, y_valid = 0, readdata = 0, history = 0, LFSR = 16'hACE1, counters = 0, FSM = IDLE, overrun = 0. Reset mid-computation aborts the sample; no y_valid.

## Structure
- Shared package lpc_pkg: coefficient width, FRAC, ORDER, LFSR seed/taps, register addresses (also used by the encoder).
- Sub-module lpc_excite: LFSR, pitch counter, excitation mux/scale; lpc_synth holds FSM, MAC, history, registers.

## Test plan
- a1 = −2048 (−0.5), rest 0, voiced, pitch 4, gain 1000 → y = 1000, 500, 250, 125, 1062.
- a1 = −4096 (−1.0), voiced, pitch 1, gain 30000 → y = 30000, 32767, 32767 (saturation, no wrap).
- Unvoiced, gain 0 → y = 0 every sample; first 3 LFSR states match reference model from 16'hACE1.
- frame_len = 4, load new gain mid-frame → new gain visible exactly at sample 4, not earlier.
- samp_en twice 5 cycles apart → one y_valid at cycle 13, status reads 1; write addr 1 → reads 0.
- rst low during MAC → all outputs 0, next samp_en produces first-frame result from zero history.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared LPC constants and types for the encoder/synthesizer pair.
package lpc_pkg;

    localparam int COEF_W   = 16;
    localparam int LPC_FRAC = 12;
    localparam int NCOEF    = 10;
    localparam int ACC_W    = 40;
    localparam int EXC_W    = 17;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [15:0] REG_FRAME_LEN = 16'd0;
    localparam logic [15:0] REG_STATUS    = 16'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXC,
        S_MAC,
        S_OUT
    } synth_state_e;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > 40'sd32767)
            return 16'sh7fff;
        else if (v < -40'sd32768)
            return 16'sh8000;
        return v[15:0];
    endfunction

endpackage

// File: rtl/lpc_excite.sv
// Excitation source: noise LFSR, pitch-period counter, voiced/unvoiced select and scaling.
module lpc_excite
    import lpc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    restart,
    input  logic                    adv,
    input  logic                    voiced,
    input  logic [15:0]             pitch,
    input  logic signed [15:0]      gain,
    output logic signed [EXC_W-1:0] e
);

    logic [15:0]        lfsr;
    logic [15:0]        pcnt;
    logic [15:0]        plast;
    logic signed [31:0] prod;

    // Pitch 0 behaves as 1, so the counter simply stays at 0
    assign plast = (pitch == 16'd0) ? 16'd0 : pitch - 16'd1;
    assign prod  = $signed(lfsr) * gain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
            pcnt <= '0;
        end else begin
            if (adv) begin
                lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
                pcnt <= (pcnt >= plast) ? 16'd0 : pcnt + 16'd1;
            end
            if (restart)
                pcnt <= '0;
        end
    end

    always_comb begin
        e = '0;
        if (voiced) begin
            if (pcnt == 16'd0)
                e = {gain[15], gain};
        end else begin
            e = prod[31:15];
        end
    end

endmodule

// File: rtl/lpc_synth.sv
// LPC synthesizer: per-sample excitation plus 10-tap all-pole filter on one shared multiplier.
module lpc_synth
    import lpc_pkg::*;
#(
    parameter int ORDER     = NCOEF,
    parameter int FRAC      = LPC_FRAC,
    parameter int FRAME_DEF = 240
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               samp_en,
    input  logic               load,
    input  logic signed [15:0] a1,
    input  logic signed [15:0] a2,
    input  logic signed [15:0] a3,
    input  logic signed [15:0] a4,
    input  logic signed [15:0] a5,
    input  logic signed [15:0] a6,
    input  logic signed [15:0] a7,
    input  logic signed [15:0] a8,
    input  logic signed [15:0] a9,
    input  logic signed [15:0] a10,
    input  logic               voiced,
    input  logic [15:0]        pitch,
    input  logic signed [15:0] gain,
    output logic signed [15:0] y,
    output logic               y_valid,
    input  logic [15:0]        address,
    input  logic               read,
    input  logic               write,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata
);

    localparam int KW = $clog2(NCOEF);
    localparam logic [KW-1:0] K_LAST = KW'(ORDER - 1);

    synth_state_e state, state_nxt;

    logic signed [15:0] a_in  [NCOEF];
    logic signed [15:0] shd_a [NCOEF];
    logic signed [15:0] act_a [NCOEF];
    logic signed [15:0] hist  [NCOEF];
    logic               shd_v, act_v;
    logic [15:0]        shd_p, act_p;
    logic signed [15:0] shd_g, act_g;

    logic [15:0]             frame_len, scnt;
    logic                    overrun;
    logic [KW-1:0]           k;
    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      prod;
    logic signed [EXC_W-1:0] e;
    logic                    accept, frame_start;

    assign a_in = '{a1, a2, a3, a4, a5, a6, a7, a8, a9, a10};

    assign accept      = (state == S_IDLE) && samp_en;
    assign frame_start = accept && (scnt == 16'd0);
    assign prod        = act_a[k] * hist[k];

    lpc_excite u_exc (
        .clk     (clk),
        .rst     (rst),
        .restart (frame_start),
        .adv     (state == S_EXC),
        .voiced  (act_v),
        .pitch   (act_p),
        .gain    (act_g),
        .e       (e)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (samp_en) state_nxt = S_EXC;
            S_EXC:   state_nxt = S_MAC;
            S_MAC:   if (k == K_LAST) state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shadow/active parameter sets and the per-frame sample counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                shd_a[i] <= '0;
                act_a[i] <= '0;
            end
            shd_v <= 1'b0;
            shd_p <= '0;
            shd_g <= '0;
            act_v <= 1'b0;
            act_p <= '0;
            act_g <= '0;
            scnt  <= '0;
        end else begin
            if (load) begin
                for (int i = 0; i < NCOEF; i++)
                    shd_a[i] <= a_in[i];
                shd_v <= voiced;
                shd_p <= pitch;
                shd_g <= gain;
            end
            if (frame_start) begin
                for (int i = 0; i < NCOEF; i++)
                    act_a[i] <= shd_a[i];
                act_v <= shd_v;
                act_p <= shd_p;
                act_g <= shd_g;
            end
            if (accept)
                scnt <= (scnt >= frame_len - 16'd1) ? 16'd0 : scnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            k       <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            for (int i = 0; i < NCOEF; i++)
                hist[i] <= '0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                S_EXC: begin
                    acc <= {{(ACC_W-EXC_W){e[EXC_W-1]}}, e} <<< FRAC;
                    k   <= '0;
                end
                S_MAC: begin
                    acc <= acc - {{(ACC_W-32){prod[31]}}, prod};
                    k   <= k + 1'b1;
                end
                S_OUT: begin
                    y       <= sat16(acc >>> FRAC);
                    y_valid <= 1'b1;
                    hist[0] <= sat16(acc >>> FRAC);
                    for (int i = 1; i < NCOEF; i++)
                        hist[i] <= hist[i-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_len <= 16'(FRAME_DEF);
            overrun   <= 1'b0;
            readdata  <= '0;
        end else begin
            if (write && address == REG_FRAME_LEN)
                frame_len <= (writedata == 16'd0) ? 16'd1 : writedata;
            if (write && address == REG_STATUS)
                overrun <= 1'b0;
            if (samp_en && state != S_IDLE)
                overrun <= 1'b1;
            if (read) begin
                case (address)
                    REG_FRAME_LEN: readdata <= frame_len;
                    REG_STATUS:    readdata <= {15'd0, overrun};
                    default:       readdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_synth.sv
// Bench for lpc_synth: directed scenarios plus randomized frames against a plain-arithmetic model.
module tb_lpc_synth;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               samp_en = 1'b0;
    logic               load = 1'b0;
    logic signed [15:0] a_drv [10];
    logic               voiced = 1'b0;
    logic [15:0]        pitch = '0;
    logic signed [15:0] gain = '0;
    logic signed [15:0] y;
    logic               y_valid;
    logic [15:0]        address = '0;
    logic               read = 1'b0;
    logic               write = 1'b0;
    logic [15:0]        writedata = '0;
    logic [15:0]        readdata;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_hist [10];
    int m_act_a [10], m_shd_a [10];
    int m_act_v, m_act_p, m_act_g, m_shd_v, m_shd_p, m_shd_g;
    int m_lfsr, m_scnt, m_pcnt, m_flen;

    always #10 clk = ~clk;

    lpc_synth dut (
        .clk(clk), .rst(rst), .samp_en(samp_en), .load(load),
        .a1(a_drv[0]), .a2(a_drv[1]), .a3(a_drv[2]), .a4(a_drv[3]), .a5(a_drv[4]),
        .a6(a_drv[5]), .a7(a_drv[6]), .a8(a_drv[7]), .a9(a_drv[8]), .a10(a_drv[9]),
        .voiced(voiced), .pitch(pitch), .gain(gain), .y(y), .y_valid(y_valid),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata)
    );

    function automatic void model_reset();
        for (int i = 0; i < 10; i++) begin
            m_hist[i] = 0; m_act_a[i] = 0; m_shd_a[i] = 0;
        end
        m_act_v = 0; m_act_p = 0; m_act_g = 0;
        m_shd_v = 0; m_shd_p = 0; m_shd_g = 0;
        m_lfsr = 'hACE1; m_scnt = 0; m_pcnt = 0; m_flen = 240;
    endfunction

    function automatic void model_capture();
        for (int i = 0; i < 10; i++) m_shd_a[i] = a_drv[i];
        m_shd_v = voiced; m_shd_p = pitch; m_shd_g = gain;
    endfunction

    function automatic int model_step();
        longint acc, e, ls;
        int fb;
        if (m_scnt == 0) begin
            m_act_a = m_shd_a;
            m_act_v = m_shd_v; m_act_p = m_shd_p; m_act_g = m_shd_g;
            m_pcnt = 0;
        end
        m_scnt = (m_scnt >= m_flen - 1) ? 0 : m_scnt + 1;
        if (m_act_v != 0) begin
            e = (m_pcnt == 0) ? m_act_g : 0;
        end else begin
            ls = (m_lfsr >= 32768) ? m_lfsr - 65536 : m_lfsr;
            e = (ls * m_act_g) >>> 15;
        end
        fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
        m_pcnt = (m_pcnt + 1) % ((m_act_p == 0) ? 1 : m_act_p);
        acc = e * 4096;
        for (int i = 0; i < 10; i++) acc -= longint'(m_act_a[i]) * m_hist[i];
        acc = acc >>> 12;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        for (int i = 9; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int'(acc);
        return int'(acc);
    endfunction

    task automatic do_reset();
        samp_en = 0; load = 0; read = 0; write = 0;
        @(negedge clk); rst = 0;
        @(negedge clk); @(negedge clk); rst = 1;
        model_reset();
    endtask

    task automatic do_load();
        @(negedge clk); load = 1; model_capture();
        @(negedge clk); load = 0;
    endtask

    task automatic reg_write(input logic [15:0] adr, input logic [15:0] d);
        @(negedge clk); address = adr; writedata = d; write = 1;
        @(negedge clk); write = 0;
        if (adr == 16'd0) m_flen = (d == 0) ? 1 : int'(d);
    endtask

    task automatic reg_read(input logic [15:0] adr, output logic [15:0] d);
        @(negedge clk); address = adr; read = 1;
        @(negedge clk); read = 0; d = readdata;
    endtask

    task automatic set_coefs(input int a1v);
        for (int i = 0; i < 10; i++) a_drv[i] = '0;
        a_drv[0] = 16'(a1v);
    endtask

    task automatic rand_inputs(input bit force_uv);
        for (int i = 0; i < 10; i++) a_drv[i] = 16'(int'($urandom_range(0, 3000)) - 1500);
        voiced = force_uv ? 1'b0 : 1'($urandom_range(0, 1));
        pitch  = 16'($urandom_range(0, 5));
        gain   = 16'(int'($urandom_range(0, 40000)) - 20000);
    endtask

    // Starts a sample at the current negedge, optional coincident load and overrun pulse
    task automatic run_sample(input string nm, input bit ld, input int extra, output int got);
        int exp_y, seen;
        exp_y = model_step();
        if (ld) model_capture();
        samp_en = 1; load = ld;
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin samp_en = 0; load = 0; end
            if (extra > 0 && c == extra) samp_en = 1;
            if (extra > 0 && c == extra + 1) samp_en = 0;
            if (y_valid) begin seen = c; break; end
        end
        n_cmp++;
        if (seen != 13) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, expected 13", nm, seen);
        end
        n_cmp++;
        if (y !== 16'(exp_y)) begin
            n_err++;
            $display("FAIL %s y: got %0d, expected %0d", nm, y, exp_y);
        end
        got = int'(y);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        do_reset();
        n_cmp++;
        if (y !== 16'd0 || y_valid !== 1'b0 || readdata !== 16'd0) begin
            n_err++;
            $display("FAIL reset outputs: y=%0d y_valid=%b readdata=%0d, expected 0", y, y_valid, readdata);
        end
        reg_read(16'd0, d);
        n_cmp++;
        if (d !== 16'd240) begin n_err++; $display("FAIL reset frame_len: got %0d, expected 240", d); end
        reg_read(16'd1, d);
        n_cmp++;
        if (d !== 16'd0) begin n_err++; $display("FAIL reset status: got %0d, expected 0", d); end
    endtask

    task automatic test_regs();
        logic [15:0] d;
        do_reset();
        reg_write(16'd0, 16'd0);
        reg_read(16'd0, d);
        n_cmp++;
        if (d !== 16'd1) begin n_err++; $display("FAIL frame_len zero: got %0d, expected 1", d); end
        reg_write(16'd0, 16'd7);
        reg_write(16'd5, 16'hBEEF);
        reg_read(16'd5, d);
        n_cmp++;
        if (d !== 16'd0) begin n_err++; $display("FAIL unmapped read: got %0d, expected 0", d); end
        reg_read(16'd0, d);
        n_cmp++;
        if (d !== 16'd7) begin n_err++; $display("FAIL frame_len write: got %0d, expected 7", d); end
    endtask

    task automatic test_voiced_decay();
        int expv [5] = '{1000, 500, 250, 125, 1062};
        int got;
        do_reset();
        set_coefs(-2048); voiced = 1; pitch = 4; gain = 1000;
        do_load();
        for (int s = 0; s < 5; s++) begin
            run_sample("decay", 0, 0, got);
            n_cmp++;
            if (got != expv[s]) begin
                n_err++; $display("FAIL decay sample %0d: got %0d, expected %0d", s, got, expv[s]);
            end
        end
    endtask

    task automatic test_saturation();
        int expv [3] = '{30000, 32767, 32767};
        int got;
        do_reset();
        set_coefs(-4096); voiced = 1; pitch = 1; gain = 30000;
        do_load();
        for (int s = 0; s < 3; s++) begin
            run_sample("sat", 0, 0, got);
            n_cmp++;
            if (got != expv[s]) begin
                n_err++; $display("FAIL sat sample %0d: got %0d, expected %0d", s, got, expv[s]);
            end
        end
    endtask

    task automatic test_unvoiced_zero();
        int got;
        do_reset();
        rand_inputs(1'b1); gain = 0;
        do_load();
        for (int s = 0; s < 3; s++) begin
            run_sample("uv0", 0, 0, got);
            n_cmp++;
            if (got != 0) begin n_err++; $display("FAIL uv0 sample %0d: got %0d, expected 0", s, got); end
            n_cmp++;
            if (dut.u_exc.lfsr !== 16'(m_lfsr)) begin
                n_err++; $display("FAIL lfsr state %0d: got %h, expected %h", s, dut.u_exc.lfsr, 16'(m_lfsr));
            end
        end
    endtask

    task automatic test_frame_gain();
        int got, expg;
        do_reset();
        reg_write(16'd0, 16'd4);
        set_coefs(0); voiced = 1; pitch = 1; gain = 1000;
        do_load();
        for (int s = 0; s < 13; s++) begin
            if (s == 2) begin gain = 2000; do_load(); end
            if (s == 8) gain = 3000;
            run_sample("frame", s == 8, 0, got);
            expg = (s < 4) ? 1000 : (s < 12) ? 2000 : 3000;
            n_cmp++;
            if (got != expg) begin
                n_err++; $display("FAIL frame gain sample %0d: got %0d, expected %0d", s, got, expg);
            end
        end
    endtask

    task automatic test_overrun();
        int got, extra_v;
        logic [15:0] d;
        do_reset();
        reg_write(16'd0, 16'd2);
        set_coefs(0); voiced = 1; pitch = 2; gain = 500;
        do_load();
        run_sample("overrun", 0, 5, got);
        extra_v = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (y_valid) extra_v++;
        end
        n_cmp++;
        if (extra_v != 0) begin n_err++; $display("FAIL overrun extra y_valid: got %0d, expected 0", extra_v); end
        reg_read(16'd1, d);
        n_cmp++;
        if (d !== 16'd1) begin n_err++; $display("FAIL overrun status: got %0d, expected 1", d); end
        reg_write(16'd1, 16'($urandom));
        reg_read(16'd1, d);
        n_cmp++;
        if (d !== 16'd0) begin n_err++; $display("FAIL overrun clear: got %0d, expected 0", d); end
        gain = 700;
        do_load();
        run_sample("post overrun 1", 0, 0, got);
        n_cmp++;
        if (got != 0) begin n_err++; $display("FAIL post overrun 1: got %0d, expected 0", got); end
        run_sample("post overrun 2", 0, 0, got);
        n_cmp++;
        if (got != 700) begin n_err++; $display("FAIL post overrun 2: got %0d, expected 700", got); end
    endtask

    task automatic test_reset_mid();
        int got, vcount;
        logic [15:0] d;
        do_reset();
        set_coefs(-2048); voiced = 1; pitch = 4; gain = 1000;
        do_load();
        run_sample("pre reset 0", 0, 0, got);
        run_sample("pre reset 1", 0, 0, got);
        reg_read(16'd0, d);
        samp_en = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            samp_en = 0;
        end
        #3 rst = 0;
        #1;
        n_cmp++;
        if (y !== 16'd0 || y_valid !== 1'b0 || readdata !== 16'd0) begin
            n_err++;
            $display("FAIL mid reset outputs: y=%0d y_valid=%b readdata=%0d, expected 0", y, y_valid, readdata);
        end
        @(negedge clk); rst = 1;
        model_reset();
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (y_valid) vcount++;
        end
        n_cmp++;
        if (vcount != 0) begin n_err++; $display("FAIL aborted sample y_valid: got %0d, expected 0", vcount); end
        do_load();
        run_sample("after reset", 0, 0, got);
        n_cmp++;
        if (got != 1000) begin n_err++; $display("FAIL after reset y: got %0d, expected 1000", got); end
    endtask

    task automatic test_random(input bit force_uv);
        int got;
        do_reset();
        reg_write(16'd0, 16'($urandom_range(2, 6)));
        rand_inputs(force_uv);
        do_load();
        for (int s = 0; s < 24; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                rand_inputs(force_uv);
                if ($urandom_range(0, 1) == 0) begin
                    do_load();
                    run_sample("random", 0, 0, got);
                end else begin
                    run_sample("random coincident", 1, 0, got);
                end
            end else begin
                run_sample("random", 0, 0, got);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) a_drv[i] = '0;
        model_reset();
        test_reset();
        test_regs();
        test_voiced_decay();
        test_saturation();
        test_unvoiced_zero();
        test_frame_gain();
        test_overrun();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
